wbu: RTL and testbench
======================

# wbu

Write-back stage at the end of the pipeline. It accepts one retired instruction per handshake from the memory stage and drives the register-file write port that the decode stage's register file samples. It also reports each commit, sends control-flow redirects back to fetch over a valid/ready handshake, and halts the core on `ebreak`.

## Interface
Parameters:
- `XLEN`, 32, data and PC width.
- `CNT_W`, 64, retire-counter width.

Ports (clk/rst_n; reset is synchronous, active-low):
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous active-low reset, sampled on `clk` rising edge.
- `in_valid`  in  1  upstream payload valid.
- `in_ready`  out  1  WBU can accept a payload.
- `in_inst_valid`  in  1  payload is a real instruction; 0 means bubble.
- `in_pc`  in  XLEN  PC of the instruction.
- `in_rd_addr`  in  5  destination register.
- `in_reg_wen`  in  1  instruction writes `rd`.
- `in_wb_data`  in  XLEN  final result (ALU, load, CSR or link value).
- `in_redirect`  in  1  instruction changes control flow.
- `in_next_pc`  in  XLEN  redirect target.
- `in_ebreak`  in  1  instruction is `ebreak`.
- `reg_wen`  out  1  register-file write enable.
- `reg_addr`  out  5  register-file write address.
- `reg_data`  out  XLEN  register-file write data.
- `redir_valid`  out  1  redirect request to IFU.
- `redir_ready`  in  1  IFU accepts the redirect.
- `redir_pc`  out  XLEN  redirect target.
- `commit_valid`  out  1  one instruction retired this cycle.
- `commit_pc`  out  XLEN  PC of the retiring instruction.
- `halt`  out  1  sticky; set by `ebreak`.
- `retire_cnt`  out  CNT_W  count of retired instructions.

## Operation
- Moore FSM with states S_IDLE, S_COMMIT, S_REDIRECT and S_HALT. All outputs depend only on state and registered payload.
- **S_IDLE**
  - Drives `in_ready`=1; all other strobes are 0.
  - On fire (`in_valid && in_ready`): latch every `in_*` field and go to S_COMMIT.
- **S_COMMIT** (exactly one cycle; `in_ready`=0)
  - `reg_wen` = `inst_valid && reg_wen && rd_addr!=0`. `reg_addr` and `reg_data` come from the latched payload.
  - `commit_valid` = `inst_valid`; `commit_pc` = latched PC.
  - `retire_cnt` increments at the end of this cycle if `inst_valid`.
  - Next state, in priority order:
    - `inst_valid && ebreak` → S_HALT.
    - `inst_valid && redirect` → S_REDIRECT.
    - otherwise → S_IDLE.
- **S_REDIRECT**
  - `redir_valid`=1 and `redir_pc` = latched `next_pc`. Both stay stable until `redir_ready`.
  - `in_ready`=0.
  - On `redir_ready` → S_IDLE.
- **S_HALT**
  - `halt`=1. `in_ready`, `reg_wen`, `commit_valid` and `redir_valid` are all 0.
  - Leaves only through reset.
- Bubbles (`in_inst_valid`=0) are consumed: no write, no commit, no count and no redirect, regardless of the other fields.
- An `ebreak` that also has `reg_wen`/`rd` set still performs its write in S_COMMIT. Its redirect is ignored.
- `retire_cnt` wraps modulo 2^CNT_W.

## Timing
- Reset values:
  - state = S_IDLE, `in_ready`=1.
  - `reg_wen`=0, `reg_addr`=0, `reg_data`=0.
  - `redir_valid`=0, `redir_pc`=0.
  - `commit_valid`=0, `commit_pc`=0.
  - `halt`=0, `retire_cnt`=0.
  - Latched payload cleared.
- Fire at edge N puts S_COMMIT in cycle N+1. The register file samples the write at edge N+2. `in_ready` returns high in cycle N+2 when there is no redirect.
- Maximum throughput is one instruction per 2 cycles.
- Redirect: `redir_valid` asserts in cycle N+2 and holds through back-pressure. If `redir_ready` is high at edge M, S_IDLE holds in cycle M+1.
- Reset mid-operation: any pending write, commit or redirect is dropped with no partial strobe in the reset cycle. `halt` clears.
- `in_*` fields are ignored whenever `in_ready`=0.

## Configuration
- `WBU_RETIRE_CNT_EN` defined: the CNT_W-bit retire counter is implemented as described above.
- Not defined: no counter flops; `retire_cnt` is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then ADD retire with pc=0x80000000, rd=5, data=0x1234 → one S_COMMIT cycle with `reg_wen`=1, addr=5, data=0x1234, `commit_pc`=0x80000000. `retire_cnt`=1 (counter enabled). `in_ready` is 0 for exactly 1 cycle.
- Retire with rd=0, reg_wen=1, data=0xFFFFFFFF → `reg_wen`=0, `commit_valid`=1, count increments.
- Payload with inst_valid=0, reg_wen=1, redirect=1, ebreak=1 → no write, no commit, no redirect, no halt; back in S_IDLE after 1 cycle.
- JAL with redirect=1, next_pc=0x80000100, and `redir_ready` held low for 3 cycles → `redir_valid`=1 with stable pc 0x80000100 for 4 cycles. `in_ready`=0 throughout and 1 the cycle after the accept.
- `ebreak` with redirect=1 → `halt` sticky; no `redir_valid`; `in_ready`=0 for 10 further cycles despite `in_valid`=1. Asserting `rst_n`=0 for 1 cycle → all outputs return to reset values.
- Reset asserted during S_REDIRECT → `redir_valid`=0 the next cycle, state S_IDLE, `retire_cnt`=0.

Source files
------------

// File: rtl/wbu.sv
// wbu: write-back stage; retires one payload per handshake, drives the register-file write port, redirects fetch and halts on ebreak (WBU_RETIRE_CNT_EN enables the retire counter)
module wbu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inst_valid,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [4:0]       in_rd_addr,
  input  logic             in_reg_wen,
  input  logic [XLEN-1:0]  in_wb_data,
  input  logic             in_redirect,
  input  logic [XLEN-1:0]  in_next_pc,
  input  logic             in_ebreak,
  output logic             reg_wen,
  output logic [4:0]       reg_addr,
  output logic [XLEN-1:0]  reg_data,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [XLEN-1:0]  redir_pc,
  output logic             commit_valid,
  output logic [XLEN-1:0]  commit_pc,
  output logic             halt,
  output logic [CNT_W-1:0] retire_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_REDIRECT, S_HALT} state_t;
  state_t state;
  logic lat_iv, lat_redirect, lat_ebreak;
  logic [XLEN-1:0] lat_next_pc;
  // state machine with registered outputs; commit strobes are loaded on the fire edge so they appear in S_COMMIT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      in_ready     <= 1'b1;
      reg_wen      <= 1'b0;
      reg_addr     <= '0;
      reg_data     <= '0;
      redir_valid  <= 1'b0;
      redir_pc     <= '0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      halt         <= 1'b0;
      lat_iv       <= 1'b0;
      lat_redirect <= 1'b0;
      lat_ebreak   <= 1'b0;
      lat_next_pc  <= '0;
    end else begin
      reg_wen      <= 1'b0;
      commit_valid <= 1'b0;
      case (state)
        S_IDLE: if (in_valid) begin
          state        <= S_COMMIT;
          in_ready     <= 1'b0;
          lat_iv       <= in_inst_valid;
          lat_redirect <= in_redirect;
          lat_ebreak   <= in_ebreak;
          lat_next_pc  <= in_next_pc;
          reg_wen      <= in_inst_valid && in_reg_wen && (in_rd_addr != 5'd0);
          reg_addr     <= in_rd_addr;
          reg_data     <= in_wb_data;
          commit_valid <= in_inst_valid;
          commit_pc    <= in_pc;
        end
        S_COMMIT: if (lat_iv && lat_ebreak) begin
          state <= S_HALT;
          halt  <= 1'b1;
        end else if (lat_iv && lat_redirect) begin
          state       <= S_REDIRECT;
          redir_valid <= 1'b1;
          redir_pc    <= lat_next_pc;
        end else begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
        S_REDIRECT: if (redir_ready) begin
          state       <= S_IDLE;
          redir_valid <= 1'b0;
          in_ready    <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`ifdef WBU_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt;
  // counts real instructions as they leave S_COMMIT; wraps naturally
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else if (state == S_COMMIT && lat_iv) cnt <= cnt + CNT_W'(1);
  end
  assign retire_cnt = cnt;
`else
  assign retire_cnt = '0;
`endif
endmodule

// File: tb/tb_wbu.sv
// tb_wbu: randomized self-checking bench for the write-back stage
module tb_wbu;
  localparam int XLEN = 32;
  localparam int CNT_W = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_inst_valid = 1'b0, in_reg_wen = 1'b0, in_redirect = 1'b0, in_ebreak = 1'b0;
  logic [XLEN-1:0] in_pc = '0, in_wb_data = '0, in_next_pc = '0;
  logic [4:0] in_rd_addr = '0;
  logic redir_ready = 1'b0;
  logic in_ready, reg_wen, redir_valid, commit_valid, halt;
  logic [4:0] reg_addr;
  logic [XLEN-1:0] reg_data, redir_pc, commit_pc;
  logic [CNT_W-1:0] retire_cnt;
  int tests = 0, fails = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  wbu #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst_valid(in_inst_valid), .in_pc(in_pc), .in_rd_addr(in_rd_addr),
    .in_reg_wen(in_reg_wen), .in_wb_data(in_wb_data), .in_redirect(in_redirect),
    .in_next_pc(in_next_pc), .in_ebreak(in_ebreak), .reg_wen(reg_wen),
    .reg_addr(reg_addr), .reg_data(reg_data), .redir_valid(redir_valid),
    .redir_ready(redir_ready), .redir_pc(redir_pc), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .halt(halt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] cnt_exp();
`ifdef WBU_RETIRE_CNT_EN
    return exp_cnt;
`else
    return '0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic garbage(input logic v);
    in_valid = v;
    in_inst_valid = 1'b1;
    in_reg_wen = 1'b1;
    in_rd_addr = 5'($urandom_range(1, 31));
    in_pc = $urandom;
    in_wb_data = $urandom;
    in_redirect = 1'($urandom);
    in_ebreak = 1'($urandom);
    in_next_pc = $urandom;
  endtask

  // one whole transaction: fire, commit cycle, then halt/redirect/idle outcome
  task automatic send(input logic iv, input logic [XLEN-1:0] pc, input logic [4:0] rd,
                      input logic wen, input logic [XLEN-1:0] data, input logic redir,
                      input logic [XLEN-1:0] npc, input logic eb, input int k, input logic noise);
    logic exp_w;
    int w = 0;
    while (!in_ready && w < 20) begin step(); w++; end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL idle_wait in_ready=%b want 1", in_ready); end
    in_valid = 1'b1; in_inst_valid = iv; in_pc = pc; in_rd_addr = rd; in_reg_wen = wen;
    in_wb_data = data; in_redirect = redir; in_next_pc = npc; in_ebreak = eb; redir_ready = 1'b0;
    step();
    garbage(noise);
    exp_w = iv && wen && (rd != 5'd0);
    tests++;
    if ({in_ready, reg_wen, commit_valid, redir_valid, halt} !== {1'b0, exp_w, iv, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL commit_strobes rdy/wen/cv/rv/halt=%b want %b",
               {in_ready, reg_wen, commit_valid, redir_valid, halt}, {1'b0, exp_w, iv, 1'b0, 1'b0});
    end
    if (exp_w) begin
      tests++;
      if ({reg_addr, reg_data} !== {rd, data}) begin
        fails++; $display("FAIL commit_write addr=%0d data=%h want %0d %h", reg_addr, reg_data, rd, data);
      end
    end
    if (iv) begin
      tests++;
      if (commit_pc !== pc) begin fails++; $display("FAIL commit_pc got %h want %h", commit_pc, pc); end
      exp_cnt++;
    end
    step();
    tests++;
    if (retire_cnt !== cnt_exp()) begin fails++; $display("FAIL retire_cnt got %0d want %0d", retire_cnt, cnt_exp()); end
    if (iv && eb) begin
      in_valid = 1'b0;
      tests++;
      if ({halt, in_ready, redir_valid, reg_wen, commit_valid} !== 5'b10000) begin
        fails++; $display("FAIL halt_entry h/rdy/rv/wen/cv=%b want 10000", {halt, in_ready, redir_valid, reg_wen, commit_valid});
      end
    end else if (iv && redir) begin
      for (int i = 0; i <= k; i++) begin
        tests++;
        if ({redir_valid, in_ready, reg_wen, commit_valid} !== 4'b1000 || redir_pc !== npc) begin
          fails++; $display("FAIL redirect_hold cyc=%0d rv/rdy/wen/cv=%b pc=%h want 1000 %h",
                            i, {redir_valid, in_ready, reg_wen, commit_valid}, redir_pc, npc);
        end
        if (i == k) redir_ready = 1'b1;
        step();
      end
      redir_ready = 1'b0;
      in_valid = 1'b0;
      tests++;
      if ({redir_valid, in_ready} !== 2'b01) begin
        fails++; $display("FAIL redirect_accept rv/rdy=%b want 01", {redir_valid, in_ready});
      end
    end else begin
      in_valid = 1'b0;
      tests++;
      if ({in_ready, reg_wen, commit_valid, redir_valid, halt} !== 5'b10000) begin
        fails++; $display("FAIL back_to_idle rdy/wen/cv/rv/h=%b want 10000", {in_ready, reg_wen, commit_valid, redir_valid, halt});
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    tests++;
    if ({in_ready, reg_wen, reg_addr, reg_data, redir_valid, redir_pc, commit_valid, commit_pc, halt, retire_cnt}
        !== {1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 64'd0}) begin
      fails++;
      $display("FAIL %s rdy=%b wen=%b a=%0d d=%h rv=%b rpc=%h cv=%b cpc=%h h=%b cnt=%0d want all reset",
               tag, in_ready, reg_wen, reg_addr, reg_data, redir_valid, redir_pc, commit_valid, commit_pc, halt, retire_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    check_reset_values("reset_state");
    rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic test_add();
    send(1'b1, 32'h8000_0000, 5'd5, 1'b1, 32'h1234, 1'b0, 32'h0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_rd0();
    send(1'b1, 32'h8000_0004, 5'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_bubble();
    send(1'b0, 32'h8000_0008, 5'd9, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h8000_0200, 1'b1, 0, 1'b0);
  endtask

  task automatic test_redirect();
    send(1'b1, 32'h8000_000C, 5'd1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0100, 1'b0, 3, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic iv;
      iv = ($urandom_range(0, 4) != 0);
      send(iv, $urandom, 5'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom,
           1'b0, $urandom_range(0, 3), 1'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  task automatic test_halt();
    send(1'b1, 32'h8000_0040, 5'd3, 1'b1, 32'hCAFE_0001, 1'b1, 32'h8000_0300, 1'b1, 0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      garbage(1'b1);
      step();
      tests++;
      if ({halt, in_ready, redir_valid, reg_wen, commit_valid} !== 5'b10000) begin
        fails++; $display("FAIL halt_sticky cyc=%0d h/rdy/rv/wen/cv=%b want 10000", i, {halt, in_ready, redir_valid, reg_wen, commit_valid});
      end
    end
    rst_n = 1'b0;
    step();
    in_valid = 1'b0;
    check_reset_values("halt_reset");
    rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic test_reset_mid_redirect();
    in_valid = 1'b1; in_inst_valid = 1'b1; in_redirect = 1'b1; in_ebreak = 1'b0;
    in_next_pc = 32'h8000_0500; in_reg_wen = 1'b1; in_rd_addr = 5'd4; in_wb_data = 32'h55;
    step();
    in_valid = 1'b0;
    step();
    tests++;
    if (redir_valid !== 1'b1) begin fails++; $display("FAIL mid_redirect_setup rv=%b want 1", redir_valid); end
    rst_n = 1'b0;
    step();
    check_reset_values("reset_in_redirect");
    rst_n = 1'b1;
    exp_cnt = '0;
    in_valid = 1'b1; in_inst_valid = 1'b1; in_redirect = 1'b0;
    rst_n = 1'b0;
    step();
    in_valid = 1'b0;
    check_reset_values("reset_at_fire");
    rst_n = 1'b1;
    send(1'b1, 32'h8000_0600, 5'd12, 1'b1, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_rd0();
    test_bubble();
    test_redirect();
    test_random();
    test_halt();
    test_reset_mid_redirect();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
